// File: rtl/pll_cfg_pkg.sv
// Shared constants and state encoding for the PLL reconfiguration scan shifter.
package pll_cfg_pkg;

  localparam int PLL_CFG_W    = 158;
  localparam int DEF_SCAN_DIV = 2;
  localparam int DEF_TIMEOUT  = 65535;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    SHIFT     = 3'd2,
    UPDATE    = 3'd3,
    WAIT_DONE = 3'd4,
    WAIT_LOCK = 3'd5,
    DONE      = 3'd6,
    DONE_ERR  = 3'd7
  } state_t;

endpackage

// File: rtl/pll_scan_clkgen.sv
// Free-running scan clock divider; ticks mark the i_clk cycle before each scanclk edge.
module pll_scan_clkgen
  import pll_cfg_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic scanclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             term;

  assign term      = (div_cnt == DIV_LAST);
  assign rise_tick = term & ~scanclk;
  assign fall_tick = term & scanclk;

  // divider counter and scan clock toggle on terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      scanclk <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      scanclk <= ~scanclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      scanclk <= scanclk;
    end
  end

endmodule

// File: rtl/pll_scan_shifter.sv
// Serialises a PLL configuration word into the reconfiguration scan chain,
// issues configupdate and waits for scandone and re-lock.
module pll_scan_shifter
  import pll_cfg_pkg::*;
#(
  parameter int CFG_W    = PLL_CFG_W,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CFG_W-1:0] i_config,
  input  logic             i_start,
  input  logic             i_scandone,
  input  logic             i_locked,
  output logic             o_scanclk,
  output logic             o_scanclkena,
  output logic             o_scandata,
  output logic             o_configupdate,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  localparam int BW = $clog2(CFG_W + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [CFG_W-1:0] sr, sr_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [WW-1:0]    wait_cnt, wait_nx;
  logic             ena_nx, data_nx, upd_nx, busy_nx, done_nx, err_nx;
  logic             rise_tick, fall_tick, rise_seen;
  logic             scandone_s1, scandone_s2, locked_s1, locked_s2;

  pll_scan_clkgen #(.SCAN_DIV(SCAN_DIV)) u_clkgen (
    .clk       (i_clk),
    .rst       (i_reset),
    .scanclk   (o_scanclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // two-flop synchronisers for the PLL status pins
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      scandone_s1 <= 1'b0;
      scandone_s2 <= 1'b0;
      locked_s1   <= 1'b0;
      locked_s2   <= 1'b0;
    end else begin
      scandone_s1 <= i_scandone;
      scandone_s2 <= scandone_s1;
      locked_s1   <= i_locked;
      locked_s2   <= locked_s1;
    end
  end

  // remembers that a scanclk rising edge happened since the last falling edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rise_seen <= 1'b0;
    end else if (rise_tick) begin
      rise_seen <= 1'b1;
    end else if (fall_tick) begin
      rise_seen <= 1'b0;
    end else begin
      rise_seen <= rise_seen;
    end
  end

  // state, datapath and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      sr             <= '0;
      bit_cnt        <= '0;
      wait_cnt       <= '0;
      o_scanclkena   <= 1'b0;
      o_scandata     <= 1'b0;
      o_configupdate <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      state          <= state_nx;
      sr             <= sr_nx;
      bit_cnt        <= bit_cnt_nx;
      wait_cnt       <= wait_nx;
      o_scanclkena   <= ena_nx;
      o_scandata     <= data_nx;
      o_configupdate <= upd_nx;
      o_busy         <= busy_nx;
      o_done         <= done_nx;
      o_error        <= err_nx;
    end
  end

  // next-state and next-output logic; data only moves on scanclk falling ticks
  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    bit_cnt_nx = bit_cnt;
    wait_nx    = wait_cnt;
    ena_nx     = o_scanclkena;
    data_nx    = o_scandata;
    upd_nx     = o_configupdate;
    busy_nx    = o_busy;
    done_nx    = 1'b0;
    err_nx     = o_error;
    case (state)
      IDLE: begin
        if (i_start) begin
          sr_nx      = i_config;
          bit_cnt_nx = BW'(CFG_W);
          err_nx     = 1'b0;
          busy_nx    = 1'b1;
          state_nx   = ARM;
        end else begin
          state_nx = IDLE;
        end
      end
      ARM: begin
        if (fall_tick) begin
          ena_nx     = 1'b1;
          data_nx    = sr[CFG_W-1];
          sr_nx      = {sr[CFG_W-2:0], 1'b0};
          bit_cnt_nx = bit_cnt - BW'(1);
          state_nx   = SHIFT;
        end else begin
          state_nx = ARM;
        end
      end
      SHIFT: begin
        if (fall_tick && (bit_cnt != '0)) begin
          data_nx    = sr[CFG_W-1];
          sr_nx      = {sr[CFG_W-2:0], 1'b0};
          bit_cnt_nx = bit_cnt - BW'(1);
        end else if (fall_tick && rise_seen) begin
          ena_nx   = 1'b0;
          data_nx  = 1'b0;
          upd_nx   = 1'b1;
          state_nx = UPDATE;
        end else begin
          state_nx = SHIFT;
        end
      end
      UPDATE: begin
        if (fall_tick) begin
          upd_nx   = 1'b0;
          wait_nx  = '0;
          state_nx = WAIT_DONE;
        end else begin
          state_nx = UPDATE;
        end
      end
      WAIT_DONE: begin
        if (scandone_s2) begin
          wait_nx  = '0;
          state_nx = WAIT_LOCK;
        end else if (wait_cnt == WAIT_LAST) begin
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          state_nx = DONE_ERR;
        end else begin
          wait_nx = wait_cnt + WW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s2) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          state_nx = DONE_ERR;
        end else begin
          wait_nx = wait_cnt + WW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      DONE_ERR: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        ena_nx   = 1'b0;
        data_nx  = 1'b0;
        upd_nx   = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_scan_shifter.sv
// Directed self-checking bench for pll_scan_shifter with a small PLL response model.
module tb_pll_scan_shifter;

  localparam int CW = 158;
  localparam logic [CW-1:0] CFG_ALT = 158'h2AAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [CW-1:0] CFG_B   = 158'h3C0F_FF00_1234_5678_9ABC_DEF0_0F0F_A5A5_C3C3_8001;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [CW-1:0] i_config;
  logic          i_start, i_scandone, i_locked;
  logic          o_scanclk, o_scanclkena, o_scandata, o_configupdate, o_busy, o_done, o_error;

  int passed = 0;
  int total  = 0;

  logic [CW-1:0] cap;
  int nbits, nupd, ena_cyc, ndone, cyc, cu_rise_cyc, cu_fall_cyc, sd_cyc, err_cyc;
  logic err_at_accept, busy_at_accept;

  pll_scan_shifter #(.CFG_W(CW), .SCAN_DIV(2), .TIMEOUT(100)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_config(i_config), .i_start(i_start),
    .i_scandone(i_scandone), .i_locked(i_locked), .o_scanclk(o_scanclk),
    .o_scanclkena(o_scanclkena), .o_scandata(o_scandata), .o_configupdate(o_configupdate),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // mode 0: scandone then lock; mode 1: no scandone; mode 2: scandone, never locks
  task automatic run_op(input logic [CW-1:0] cfg, input int mode, input int inj_cyc,
                        input logic [CW-1:0] inj_cfg, input int rst_bit);
    logic prev_sclk, prev_cu, prev_err, seen_busy;
    int tail, bad;
    bit fin;
    cap = '0; nbits = 0; nupd = 0; ena_cyc = 0; ndone = 0;
    cu_rise_cyc = -1000; cu_fall_cyc = -1000; sd_cyc = -1000; err_cyc = -1000;
    i_scandone = 1'b0; i_locked = 1'b0;
    i_config = cfg; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    err_at_accept = o_error; busy_at_accept = o_busy;
    prev_sclk = o_scanclk; prev_cu = o_configupdate; prev_err = o_error; seen_busy = o_busy;
    cyc = 0; tail = -1; fin = 1'b0;
    while (!fin) begin
      @(negedge i_clk);
      cyc++;
      if (i_start) i_start = 1'b0;
      if (o_scanclk && !prev_sclk) begin
        if (o_scanclkena) begin
          cap = {cap[CW-2:0], o_scandata};
          nbits++;
        end
        if (o_configupdate) nupd++;
      end
      if (o_scanclkena) ena_cyc++;
      if (o_done) ndone++;
      if (o_configupdate && !prev_cu) cu_rise_cyc = cyc;
      if (!o_configupdate && prev_cu) cu_fall_cyc = cyc;
      if (o_error && !prev_err) err_cyc = cyc;
      if (mode != 1 && cu_rise_cyc >= 0 && cyc == cu_rise_cyc + 10) begin
        i_scandone = 1'b1;
        sd_cyc = cyc;
      end
      if (mode == 0 && sd_cyc >= 0 && cyc == sd_cyc + 20) i_locked = 1'b1;
      if (cyc == inj_cyc) begin
        i_config = inj_cfg;
        i_start = 1'b1;
      end
      prev_sclk = o_scanclk; prev_cu = o_configupdate; prev_err = o_error;
      if (o_busy) seen_busy = 1'b1;
      if (tail < 0 && seen_busy && !o_busy) tail = 5;
      else if (tail > 0) tail--;
      if (tail == 0) fin = 1'b1;
      if (rst_bit > 0 && nbits == rst_bit) begin
        i_reset = 1'b1;
        #1;
        total++;
        if ({o_scanclk, o_scanclkena, o_scandata, o_configupdate, o_busy, o_done, o_error} !== 7'b0) begin
          $display("FAIL reset_mid_outputs: got %b want 0000000",
                   {o_scanclk, o_scanclkena, o_scandata, o_configupdate, o_busy, o_done, o_error});
        end else passed++;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
          @(negedge i_clk);
          if (o_configupdate || o_busy || o_scanclkena) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL reset_mid_quiet: got %0d active cycles want 0", bad);
        else passed++;
        fin = 1'b1;
      end
      if (!fin && cyc >= 3000) begin
        total++;
        $display("FAIL op_budget: got %0d cycles without return to idle want < 3000", cyc);
        fin = 1'b1;
      end
    end
    i_start = 1'b0; i_scandone = 1'b0; i_locked = 1'b0;
  endtask

  task automatic test_reset();
    int bad_clk, bad_out;
    logic exp_clk;
    i_reset = 1'b1; i_start = 1'b0; i_config = '0; i_scandone = 1'b0; i_locked = 1'b0;
    repeat (2) @(negedge i_clk);
    total++; if (o_scanclk !== 1'b0) $display("FAIL rst_scanclk: got %b want 0", o_scanclk); else passed++;
    total++; if (o_scanclkena !== 1'b0) $display("FAIL rst_ena: got %b want 0", o_scanclkena); else passed++;
    total++; if (o_scandata !== 1'b0) $display("FAIL rst_data: got %b want 0", o_scandata); else passed++;
    total++; if (o_configupdate !== 1'b0) $display("FAIL rst_cu: got %b want 0", o_configupdate); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else passed++;
    total++; if (o_done !== 1'b0) $display("FAIL rst_done: got %b want 0", o_done); else passed++;
    total++; if (o_error !== 1'b0) $display("FAIL rst_error: got %b want 0", o_error); else passed++;
    i_reset = 1'b0;
    bad_clk = 0; bad_out = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      exp_clk = ((k / 2) % 2) == 1;
      if (o_scanclk !== exp_clk) bad_clk++;
      if ({o_scanclkena, o_scandata, o_configupdate, o_busy, o_done, o_error} !== 6'b0) bad_out++;
    end
    total++; if (bad_clk !== 0) $display("FAIL idle_scanclk: got %0d wrong cycles want 0", bad_clk); else passed++;
    total++; if (bad_out !== 0) $display("FAIL idle_outputs: got %0d active cycles want 0", bad_out); else passed++;
  endtask

  task automatic test_main();
    run_op(CFG_ALT, 0, -1, '0, 0);
    total++; if (busy_at_accept !== 1'b1) $display("FAIL main_busy: got %b want 1", busy_at_accept); else passed++;
    total++; if (ena_cyc !== 632) $display("FAIL main_ena_cycles: got %0d want 632", ena_cyc); else passed++;
    total++; if (nbits !== 158) $display("FAIL main_bits: got %0d want 158", nbits); else passed++;
    total++; if (cap !== CFG_ALT) $display("FAIL main_data: got %h want %h", cap, CFG_ALT); else passed++;
    total++; if (nupd !== 1) $display("FAIL main_cu_edges: got %0d want 1", nupd); else passed++;
    total++; if (ndone !== 1) $display("FAIL main_done: got %0d want 1", ndone); else passed++;
    total++; if (o_error !== 1'b0) $display("FAIL main_error: got %b want 0", o_error); else passed++;
  endtask

  task automatic test_second_start();
    run_op(CFG_B, 0, 100, CFG_ALT, 0);
    total++; if (cap !== CFG_B) $display("FAIL second_data: got %h want %h", cap, CFG_B); else passed++;
    total++; if (ena_cyc !== 632) $display("FAIL second_ena_cycles: got %0d want 632", ena_cyc); else passed++;
    total++; if (ndone !== 1) $display("FAIL second_done: got %0d want 1", ndone); else passed++;
    total++; if (nupd !== 1) $display("FAIL second_cu_edges: got %0d want 1", nupd); else passed++;
  endtask

  task automatic test_timeout_done();
    run_op(CFG_B, 1, -1, '0, 0);
    total++; if (err_cyc - cu_fall_cyc !== 100) $display("FAIL tod_latency: got %0d want 100", err_cyc - cu_fall_cyc); else passed++;
    total++; if (o_error !== 1'b1) $display("FAIL tod_error: got %b want 1", o_error); else passed++;
    total++; if (ndone !== 0) $display("FAIL tod_done: got %0d want 0", ndone); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL tod_busy: got %b want 0", o_busy); else passed++;
    run_op(CFG_ALT, 0, -1, '0, 0);
    total++; if (err_at_accept !== 1'b0) $display("FAIL tod_clear: got %b want 0", err_at_accept); else passed++;
    total++; if (ndone !== 1) $display("FAIL tod_recover_done: got %0d want 1", ndone); else passed++;
  endtask

  task automatic test_timeout_lock();
    run_op(CFG_ALT, 2, -1, '0, 0);
    total++; if (err_cyc - sd_cyc !== 103) $display("FAIL tol_latency: got %0d want 103", err_cyc - sd_cyc); else passed++;
    total++; if (o_error !== 1'b1) $display("FAIL tol_error: got %b want 1", o_error); else passed++;
    total++; if (ndone !== 0) $display("FAIL tol_done: got %0d want 0", ndone); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL tol_busy: got %b want 0", o_busy); else passed++;
  endtask

  task automatic test_reset_mid();
    run_op(CFG_ALT, 0, -1, '0, 70);
    total++; if (nupd !== 0) $display("FAIL rmid_cu_edges: got %0d want 0", nupd); else passed++;
    run_op(CFG_B, 0, -1, '0, 0);
    total++; if (nbits !== 158) $display("FAIL rmid_bits: got %0d want 158", nbits); else passed++;
    total++; if (cap !== CFG_B) $display("FAIL rmid_data: got %h want %h", cap, CFG_B); else passed++;
    total++; if (ndone !== 1) $display("FAIL rmid_done: got %0d want 1", ndone); else passed++;
  endtask

  initial begin
    test_reset();
    test_main();
    test_second_start();
    test_timeout_done();
    test_timeout_lock();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
